// File: rtl/sf_status_poller_if.sv
// Generic single-lane QSPI command interface between a system-side sequencer and the SPI engine.
// The sysdrv modport is the sequencer view; the solo modport is the engine view.
interface pmod_generic_qspi_solo_intf #(
  parameter int unsigned parm_tx_len_bits   = 11,
  parameter int unsigned parm_wait_cyc_bits = 2,
  parameter int unsigned parm_rx_len_bits   = 11
);
  logic                          go_enhan;
  logic                          go_quadio;
  logic [parm_tx_len_bits-1:0]   tx_len;
  logic [parm_wait_cyc_bits-1:0] wait_cyc;
  logic [parm_rx_len_bits-1:0]   rx_len;
  logic [7:0]                    tx_data;
  logic                          tx_enqueue;
  logic                          rx_dequeue;
  logic                          tx_ready;
  logic                          spi_idle;
  logic                          rx_avail;
  logic                          rx_valid;
  logic [7:0]                    rx_data;

  modport qspi_sysdrv (
    output go_enhan, go_quadio, tx_len, wait_cyc, rx_len, tx_data, tx_enqueue, rx_dequeue,
    input  tx_ready, spi_idle, rx_avail, rx_valid, rx_data
  );

  modport qspi_solo (
    input  go_enhan, go_quadio, tx_len, wait_cyc, rx_len, tx_data, tx_enqueue, rx_dequeue,
    output tx_ready, spi_idle, rx_avail, rx_valid, rx_data
  );
endinterface

// File: rtl/sf_status_poller.sv
// Polls a serial-flash status register with RDSR (0x05) until WIP clears or the poll limit is hit.
// Optional abort input is enabled by defining SF_POLL_ABORT_EN.
module sf_status_poller #(
  parameter int unsigned parm_tx_len_bits   = 11,
  parameter int unsigned parm_wait_cyc_bits = 2,
  parameter int unsigned parm_rx_len_bits   = 11,
  parameter int unsigned parm_poll_limit    = 1000,
  parameter int unsigned parm_gap_cycles    = 16
) (
  input  logic        i_ext_spi_clk_x,
  input  logic        i_srst,
`ifdef SF_POLL_ABORT_EN
  input  logic        i_abort,
`endif
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [7:0]  o_status,
  output logic [15:0] o_poll_count,
  pmod_generic_qspi_solo_intf.qspi_sysdrv sdrv
);
  localparam logic [7:0] RDSR_CMD = 8'h05;

  typedef enum logic [3:0] {
    IDLE, ENQ, GO, WAIT_START, WAIT_END, DEQ, CAPTURE, CHECK, GAP
  } state_t;

  state_t      state_q, state_d;
  logic        go_enhan_q, go_enhan_d;
  logic        tx_enqueue_q, tx_enqueue_d;
  logic        rx_dequeue_q, rx_dequeue_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] poll_count_q, poll_count_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        abort_pend_q, abort_pend_d;
  logic        abort_req;

`ifdef SF_POLL_ABORT_EN
  assign abort_req = i_abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    go_enhan_d   = go_enhan_q;
    tx_enqueue_d = 1'b0;
    rx_dequeue_d = 1'b0;
    tx_data_d    = tx_data_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    status_d     = status_q;
    poll_count_d = poll_count_q;
    gap_cnt_d    = gap_cnt_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        go_enhan_d   = 1'b0;
        if (i_start) begin
          poll_count_d = 16'h0000;
          state_d      = ENQ;
        end
      end
      ENQ: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (sdrv.tx_ready) begin
          tx_data_d    = RDSR_CMD;
          tx_enqueue_d = 1'b1;
          state_d      = GO;
        end
      end
      GO: begin
        go_enhan_d = 1'b1;
        state_d    = WAIT_START;
      end
      // go_enhan is held until the engine shows it has picked up the command.
      WAIT_START: begin
        if (!sdrv.spi_idle) begin
          go_enhan_d = 1'b0;
          state_d    = WAIT_END;
        end
      end
      WAIT_END: begin
        if (sdrv.spi_idle) begin
          poll_count_d = (poll_count_q == 16'hFFFF) ? poll_count_q : poll_count_q + 16'd1;
          state_d      = DEQ;
        end
      end
      DEQ: begin
        if (sdrv.rx_avail) begin
          rx_dequeue_d = 1'b1;
          state_d      = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sdrv.rx_valid) begin
          status_d = sdrv.rx_data;
          state_d  = (abort_pend_q || abort_req) ? IDLE : CHECK;
        end
      end
      CHECK: begin
        if (!status_q[0]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (32'(poll_count_q) >= parm_poll_limit) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = 16'h0000;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (32'(gap_cnt_q) + 32'd1 >= parm_gap_cycles) begin
          state_d = ENQ;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An abort once a transaction is on the wire is remembered until the byte is drained.
    if (abort_req && (state_q inside {GO, WAIT_START, WAIT_END, DEQ, CAPTURE}))
      abort_pend_d = 1'b1;
  end

  always_ff @(posedge i_ext_spi_clk_x or posedge i_srst) begin
    if (i_srst) begin
      state_q      <= IDLE;
      go_enhan_q   <= 1'b0;
      tx_enqueue_q <= 1'b0;
      rx_dequeue_q <= 1'b0;
      tx_data_q    <= 8'h00;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      status_q     <= 8'h00;
      poll_count_q <= 16'h0000;
      gap_cnt_q    <= 16'h0000;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      go_enhan_q   <= go_enhan_d;
      tx_enqueue_q <= tx_enqueue_d;
      rx_dequeue_q <= rx_dequeue_d;
      tx_data_q    <= tx_data_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      status_q     <= status_d;
      poll_count_q <= poll_count_d;
      gap_cnt_q    <= gap_cnt_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign o_busy       = (state_q != IDLE);
  assign o_done       = done_q;
  assign o_timeout    = timeout_q;
  assign o_status     = status_q;
  assign o_poll_count = poll_count_q;

  assign sdrv.go_enhan   = go_enhan_q;
  assign sdrv.tx_enqueue = tx_enqueue_q;
  assign sdrv.rx_dequeue = rx_dequeue_q;
  assign sdrv.tx_data    = tx_data_q;
  assign sdrv.go_quadio  = 1'b0;
  assign sdrv.tx_len     = parm_tx_len_bits'(1);
  assign sdrv.rx_len     = parm_rx_len_bits'(1);
  assign sdrv.wait_cyc   = parm_wait_cyc_bits'(0);
endmodule

// File: tb/tb_sf_status_poller.sv
// Scoreboard bench for sf_status_poller: a driver model answers RDSR with queued status bytes,
// expected run outcomes are queued at start and checked by an independent monitor.
module tb_sf_status_poller;
  localparam int LIMIT = 4;
  localparam int GAP   = 16;

  typedef struct {
    bit         is_done;
    int         cnt;
    logic [7:0] status;
  } exp_t;

  logic        clk = 1'b0;
  logic        srst;
  logic        start;
  logic        busy, done, timeout;
  logic [7:0]  status;
  logic [15:0] poll_count;
`ifdef SF_POLL_ABORT_EN
  logic        abort = 1'b0;
`endif

  pmod_generic_qspi_solo_intf sdrv_if ();

  sf_status_poller #(
    .parm_poll_limit (LIMIT),
    .parm_gap_cycles (GAP)
  ) dut (
    .i_ext_spi_clk_x (clk),
    .i_srst          (srst),
`ifdef SF_POLL_ABORT_EN
    .i_abort         (abort),
`endif
    .i_start         (start),
    .o_busy          (busy),
    .o_done          (done),
    .o_timeout       (timeout),
    .o_status        (status),
    .o_poll_count    (poll_count),
    .sdrv            (sdrv_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];
  logic [7:0] resp_q[$];
  int enq_cnt = 0;
  int stall_left = 0;
  int spi_ph = 0;
  int spi_cnt = 0;
  bit pend_valid = 0;
  int cyc = 0;
  int last_deq = 0;
  bit have_deq = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Driver-side model of the SPI engine: random tx_ready, random transfer latency.
  initial begin
    sdrv_if.tx_ready = 1'b1;
    sdrv_if.spi_idle = 1'b1;
    sdrv_if.rx_avail = 1'b0;
    sdrv_if.rx_valid = 1'b0;
    sdrv_if.rx_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (srst) begin
        spi_ph = 0; pend_valid = 0;
        sdrv_if.spi_idle = 1'b1; sdrv_if.rx_avail = 1'b0; sdrv_if.rx_valid = 1'b0;
        continue;
      end
      if (stall_left > 0) begin
        sdrv_if.tx_ready = 1'b0;
        stall_left--;
      end else begin
        sdrv_if.tx_ready = ($urandom_range(0, 3) != 0);
      end
      if (sdrv_if.tx_enqueue) begin
        enq_cnt++;
        chk("tx_data", int'(sdrv_if.tx_data), 5);
      end
      case (spi_ph)
        0: if (sdrv_if.go_enhan) begin spi_ph = 1; spi_cnt = $urandom_range(0, 2); end
        1: if (spi_cnt == 0) begin
             sdrv_if.spi_idle = 1'b0; spi_ph = 2; spi_cnt = $urandom_range(2, 5);
           end else spi_cnt--;
        2: if (spi_cnt == 0) begin
             sdrv_if.spi_idle = 1'b1; sdrv_if.rx_avail = 1'b1; spi_ph = 0;
           end else spi_cnt--;
        default: spi_ph = 0;
      endcase
      sdrv_if.rx_valid = 1'b0;
      if (pend_valid) begin
        sdrv_if.rx_valid = 1'b1;
        sdrv_if.rx_data  = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
        pend_valid = 0;
      end
      if (sdrv_if.rx_dequeue) begin
        sdrv_if.rx_avail = 1'b0;
        pend_valid = 1;
      end
    end
  end

  // Monitor: pops the expected outcome whenever the poller reports completion.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!srst) begin
      if (sdrv_if.rx_dequeue) begin
        last_deq = cyc;
        have_deq = 1;
      end
      if (sdrv_if.tx_enqueue && have_deq) begin
        total++;
        if (cyc - last_deq < GAP + 4) begin
          bad++;
          $display("FAIL poll_gap: got %0d cycles expected >= %0d", cyc - last_deq, GAP + 4);
        end
      end
      if (done && timeout) chk("done_and_timeout", 1, 0);
      if (done || timeout) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("kind_done", int'(done), int'(e.is_done));
          chk("poll_count", int'(poll_count), e.cnt);
          chk("status", int'(status), int'(e.status));
          chk("enqueues", enq_cnt, e.cnt);
          chk("busy_after", int'(busy), 0);
        end
      end
    end
  end

  // Reference outcome: first byte with WIP clear ends the run, else the limit does.
  task automatic do_run(input logic [7:0] seq[$]);
    exp_t e;
    int   n;
    int   budget;
    n = (seq.size() < LIMIT) ? seq.size() : LIMIT;
    e.is_done = 0;
    e.cnt     = n;
    for (int i = 0; i < n; i++) begin
      if (!seq[i][0]) begin
        e.is_done = 1;
        e.cnt     = i + 1;
        break;
      end
    end
    e.status = seq[e.cnt - 1];
    resp_q   = seq;
    enq_cnt  = 0;
    have_deq = 0;
    exp_q.push_back(e);
    $display("run: %0d bytes, expect %s after %0d polls, status %02h",
             seq.size(), e.is_done ? "done" : "timeout", e.cnt, e.status);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on_start", int'(busy), 1);
    budget = 4000;
    while ((exp_q.size() != 0 || start) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (start) start = 1'b0;
      else if (busy && $urandom_range(0, 15) == 0) start = 1'b1;
    end
    if (budget == 0) begin
      chk("run_timeout", 1, 0);
      exp_q.delete();
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resp_q.delete();
  endtask

  logic [7:0] q[$];

  initial begin
    int budget;
    logic [7:0] b;
    int len;
    srst  = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_count", int'(poll_count), 0);
    chk("rst_tx_data", int'(sdrv_if.tx_data), 0);
    srst = 1'b0;
    @(posedge clk); #1;
    chk("tx_len", int'(sdrv_if.tx_len), 1);
    chk("rx_len", int'(sdrv_if.rx_len), 1);
    chk("wait_cyc", int'(sdrv_if.wait_cyc), 0);
    chk("go_quadio", int'(sdrv_if.go_quadio), 0);

    q.delete(); q.push_back(8'h00);
    do_run(q);
    q.delete(); q.push_back(8'h03); q.push_back(8'h03); q.push_back(8'h02);
    do_run(q);
    q.delete(); repeat (LIMIT + 1) q.push_back(8'h01);
    do_run(q);
    stall_left = 12;
    q.delete(); q.push_back(8'hA4);
    do_run(q);

    // Reset while a transfer is on the wire must abandon the run silently.
    q.delete(); repeat (LIMIT) q.push_back(8'h01);
    resp_q = q; enq_cnt = 0; have_deq = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 200;
    while (!(spi_ph == 2 && poll_count == 16'd1) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("reach_wait_end", int'(budget > 0), 1);
    #2;
    srst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_timeout", int'(timeout), 0);
    chk("arst_go", int'(sdrv_if.go_enhan), 0);
    chk("arst_enq", int'(sdrv_if.tx_enqueue), 0);
    chk("arst_deq", int'(sdrv_if.rx_dequeue), 0);
    chk("arst_status", int'(status), 0);
    chk("arst_count", int'(poll_count), 0);
    chk("arst_tx_data", int'(sdrv_if.tx_data), 0);
    @(posedge clk); @(posedge clk); #1;
    srst = 1'b0;
    resp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    q.delete(); q.push_back(8'h01); q.push_back(8'h00);
    do_run(q);

    for (int r = 0; r < 8; r++) begin
      q.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        if (i < len - 1) b[0] = 1'b1;
        else if (len < LIMIT) b[0] = 1'b0;
        q.push_back(b);
      end
      do_run(q);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sf_status_poller.md
SF_STATUS_POLLER -- requirements
Module: sf_status_poller

Interface
REQ-001 SHALL have parameter parm_tx_len_bits, default 11, width of tx_len.
REQ-002 SHALL have parameter parm_wait_cyc_bits, default 2, width of wait_cyc.
REQ-003 SHALL have parameter parm_rx_len_bits, default 11, width of rx_len.
REQ-004 SHALL have parameter parm_poll_limit, default 1000, maximum RDSR transactions before timeout.
REQ-005 SHALL have parameter parm_gap_cycles, default 16, idle clocks between polls.
REQ-006 SHALL have port i_ext_spi_clk_x, input, 1, the single system clock; all logic on its rising edge.
REQ-007 SHALL have port i_srst, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port i_start, input, 1, one-cycle request to begin polling.
REQ-009 SHALL have port o_busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port o_done, output, 1, one-cycle pulse: WIP observed clear.
REQ-011 SHALL have port o_timeout, output, 1, one-cycle pulse: poll limit reached with WIP set.
REQ-012 SHALL have port o_status, output, 8, last status byte read.
REQ-013 SHALL have port o_poll_count, output, 16, RDSR transactions issued in the current run.
REQ-014 SHALL have port sdrv, interface modport qspi_sysdrv of pmod_generic_qspi_solo_intf, driving go_enhan, go_quadio, tx_len, wait_cyc, rx_len, tx_data, tx_enqueue, rx_dequeue.

Function
REQ-015 SHALL implement states IDLE, ENQ, GO, WAIT_START, WAIT_END, DEQ, CAPTURE, CHECK, GAP.
REQ-016 IDLE: i_start high -> clear o_poll_count, go to ENQ; i_start ignored in every other state.
REQ-017 ENQ: when tx_ready high, tx_data=8'h05 and tx_enqueue high for exactly one cycle, then GO; stall while tx_ready low.
REQ-018 tx_len=1, rx_len=1, wait_cyc=0, go_quadio=0 held constant at all times.
REQ-019 GO: assert go_enhan, go to WAIT_START; go_enhan stays high until spi_idle sampled low, then low next cycle.
REQ-020 WAIT_START: spi_idle low -> WAIT_END; WAIT_END: spi_idle high -> DEQ; o_poll_count increments on WAIT_END exit.
REQ-021 DEQ: when rx_avail high, rx_dequeue high for exactly one cycle, then CAPTURE.
REQ-022 CAPTURE: o_status loads rx_data in the cycle rx_valid is high, then CHECK.
REQ-023 CHECK: o_status[0]=0 -> o_done pulse, IDLE; else o_poll_count=parm_poll_limit -> o_timeout pulse, IDLE; else GAP.
REQ-024 GAP: count parm_gap_cycles clocks, then ENQ; gap counter cleared on GAP entry.
REQ-025 o_poll_count SHALL saturate at 16'hFFFF, never wrap.
REQ-026 o_done and o_timeout SHALL never be high in the same cycle.
REQ-027 tx_enqueue, rx_dequeue, go_enhan SHALL be registered outputs.

Reset
REQ-028 On i_srst high, asynchronously: state=IDLE; o_busy, o_done, o_timeout, go_enhan, tx_enqueue, rx_dequeue=0; o_status=8'h00; o_poll_count=0; tx_data=8'h00.
REQ-029 Reset mid-transaction SHALL abandon it; no o_done/o_timeout pulse; first cycle after release is IDLE.

Configuration
REQ-030 SF_POLL_ABORT_EN defined: input i_abort (1 bit) exists; abort in ENQ (before enqueue) or GAP -> IDLE next cycle; in GO through CAPTURE -> completes transaction, then IDLE instead of CHECK; no o_done/o_timeout pulse on abort.
REQ-031 SF_POLL_ABORT_EN undefined: no i_abort port; behaviour per REQ-015..027 only.

Verification
REQ-032 Start, driver returns 8'h00 first poll -> one enqueue of 8'h05, o_poll_count=1, o_status=8'h00, o_done one cycle, o_busy low after.
REQ-033 Returns 8'h03, 8'h03, 8'h02 -> three transactions separated by >=16 idle clocks, o_poll_count=3, o_status=8'h02, o_done once.
REQ-034 parm_poll_limit=4, always 8'h01 -> exactly 4 transactions, o_timeout one cycle, o_done never high.
REQ-035 tx_ready held low 10 cycles in ENQ -> tx_enqueue waits, fires once; i_start pulsed while busy -> ignored.
REQ-036 i_srst asserted during WAIT_END -> all outputs at reset values same cycle, no pulses, new i_start restarts with o_poll_count=0.
REQ-037 SF_POLL_ABORT_EN, i_abort in GAP -> IDLE next cycle; in WAIT_END -> rx_dequeue occurs, then IDLE, no o_done.
